// File: rtl/mips_alu.sv
// ---------------------------------------------------------------------------
// mips_alu
//
// Single-cycle-latency 32-bit MIPS-style ALU. Operands and command are
// sampled on each rising clk edge and the result plus flags are registered,
// so a new operation can be issued every cycle with no handshake.
//
// Ports
//   clk      in   1   rising-edge clock
//   reset_n  in   1   synchronous active-low reset (outputs -> res=0, zero=1)
//   opA      in  32   operand A, two's complement
//   opB      in  32   operand B, two's complement
//   cin      in   1   carry-in, consumed by ADD only
//   cmd      in   3   0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 ERROR, 6 NOR, 7 OR
//   res      out 32   registered result
//   zero     out  1   registered, 1 when res is all zeros
//   ovf      out  1   registered signed overflow (ADD/SUB only)
//   cout     out  1   registered carry (ADD) or borrow (SUB)
// ---------------------------------------------------------------------------
module mips_alu (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic        cin,
    input  logic [2:0]  cmd,
    output logic [31:0] res,
    output logic        zero,
    output logic        ovf,
    output logic        cout
);

    localparam logic [2:0] CMD_ADD = 3'd0;
    localparam logic [2:0] CMD_SUB = 3'd1;
    localparam logic [2:0] CMD_XOR = 3'd2;
    localparam logic [2:0] CMD_SLT = 3'd3;
    localparam logic [2:0] CMD_AND = 3'd4;
    localparam logic [2:0] CMD_ERR = 3'd5;
    localparam logic [2:0] CMD_NOR = 3'd6;
    localparam logic [2:0] CMD_OR  = 3'd7;

    // Bitwise results, built per bit so each lane is a single LUT function.
    logic [31:0] and_bits;
    logic [31:0] or_bits;
    logic [31:0] xor_bits;
    logic [31:0] nor_bits;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi = gi + 1) begin : g_logic
            assign and_bits[gi] = opA[gi] & opB[gi];
            assign or_bits[gi]  = opA[gi] | opB[gi];
            assign xor_bits[gi] = opA[gi] ^ opB[gi];
            assign nor_bits[gi] = ~(opA[gi] | opB[gi]);
        end
    endgenerate

    // 33-bit adders: bit 32 is the carry out of bit 31.
    logic [32:0] sum_full;
    logic [32:0] diff_full;
    logic        add_ovf;
    logic        sub_ovf;
    logic        slt_bit;

    assign sum_full  = {1'b0, opA} + {1'b0, opB} + {32'd0, cin};
    // Subtract as opA + ~opB + 1; the raw carry is the inverse of borrow.
    assign diff_full = {1'b0, opA} + {1'b0, ~opB} + 33'd1;

    assign add_ovf = (opA[31] == opB[31]) && (sum_full[31] != opA[31]);
    assign sub_ovf = (opA[31] != opB[31]) && (diff_full[31] != opA[31]);
    // Sign of the difference corrected by overflow gives a true signed
    // less-than even at the extremes (e.g. 0x80000000 vs 0x7FFFFFFF).
    assign slt_bit = diff_full[31] ^ sub_ovf;

    logic [31:0] res_next;
    logic        cout_next;
    logic        ovf_next;

    always_comb begin
        res_next  = 32'd0;
        cout_next = 1'b0;
        ovf_next  = 1'b0;
        case (cmd)
            CMD_ADD: begin
                res_next  = sum_full[31:0];
                cout_next = sum_full[32];
                ovf_next  = add_ovf;
            end
            CMD_SUB: begin
                res_next  = diff_full[31:0];
                cout_next = ~diff_full[32];
                ovf_next  = sub_ovf;
            end
            CMD_XOR: res_next = xor_bits;
            CMD_SLT: res_next = {31'd0, slt_bit};
            CMD_AND: res_next = and_bits;
            CMD_ERR: res_next = 32'd0;
            CMD_NOR: res_next = nor_bits;
            CMD_OR:  res_next = or_bits;
            default: res_next = 32'd0;
        endcase
    end

    logic [31:0] res_reg;
    logic        zero_reg;
    logic        ovf_reg;
    logic        cout_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            res_reg  <= 32'd0;
            zero_reg <= 1'b1;
            ovf_reg  <= 1'b0;
            cout_reg <= 1'b0;
        end else begin
            res_reg  <= res_next;
            zero_reg <= (res_next == 32'd0);
            ovf_reg  <= ovf_next;
            cout_reg <= cout_next;
        end
    end

    assign res  = res_reg;
    assign zero = zero_reg;
    assign ovf  = ovf_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_mips_alu.sv
// ---------------------------------------------------------------------------
// tb_mips_alu
//
// Directed self-checking bench for mips_alu. Each task applies a small table
// of operations with hand-computed results and compares res/cout/ovf/zero
// one cycle after each operation is applied.
// ---------------------------------------------------------------------------
module tb_mips_alu;

    logic        clk;
    logic        reset_n;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        cin;
    logic [2:0]  cmd;
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic        cout;

    int checks;
    int failures;

    mips_alu dut (
        .clk     (clk),
        .reset_n (reset_n),
        .opA     (opA),
        .opB     (opB),
        .cin     (cin),
        .cmd     (cmd),
        .res     (res),
        .zero    (zero),
        .ovf     (ovf),
        .cout    (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic [31:0] res;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    // Apply one operation, let one rising edge capture it, and return 1 ns
    // after that edge so outputs are sampled away from the clock.
    task automatic drive(input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic ci);
        cmd = c;
        opA = a;
        opB = b;
        cin = ci;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        checks++;
        if ({res, cout, ovf, zero} !== {32'd0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_over_add: got res=%h cout=%b ovf=%b zero=%b, want res=00000000 cout=0 ovf=0 zero=1",
                     res, cout, ovf, zero);
        end else
            $display("reset_over_add: res=%h cout=%b ovf=%b zero=%b", res, cout, ovf, zero);
        // First edge with reset released captures the operation present.
        reset_n = 1'b1;
        drive(3'd0, 32'h00000005, 32'h00000007, 1'b0);
        checks++;
        if ({res, cout, ovf, zero} !== {32'h0000000C, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_release_capture: got res=%h cout=%b ovf=%b zero=%b, want res=0000000c cout=0 ovf=0 zero=0",
                     res, cout, ovf, zero);
        end else
            $display("reset_release_capture: res=%h", res);
    endtask

    task automatic test_sync_reset();
        // Load a non-reset value, then assert reset mid-cycle: nothing may
        // change until the next rising edge.
        drive(3'd0, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        drive(3'd0, 32'h12345678, 32'h11111111, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({res, cout, ovf, zero} !== {32'h23456789, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_not_async: got res=%h zero=%b, want res=23456789 zero=0", res, zero);
        end else
            $display("reset_not_async: res=%h zero=%b", res, zero);
        @(posedge clk);
        #1;
        checks++;
        if ({res, cout, ovf, zero} !== {32'd0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_on_edge: got res=%h cout=%b ovf=%b zero=%b, want res=00000000 cout=0 ovf=0 zero=1",
                     res, cout, ovf, zero);
        end else
            $display("reset_on_edge: res=%h zero=%b", res, zero);
        reset_n = 1'b1;
    endtask

    task automatic test_add();
        vec_t v[$];
        v.push_back({3'd0, 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0});
        v.push_back({3'd0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1});
        v.push_back({3'd0, 32'hFFFFFFFB, 32'h80000000, 1'b0, 32'h7FFFFFFB, 1'b1, 1'b1, 1'b0});
        v.push_back({3'd0, 32'h00000001, 32'h00000001, 1'b1, 32'h00000003, 1'b0, 1'b0, 1'b0});
        v.push_back({3'd0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0});
        v.push_back({3'd0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1});
        foreach (v[i]) begin
            drive(v[i].cmd, v[i].a, v[i].b, v[i].ci);
            checks++;
            if ({res, cout, ovf, zero} !== {v[i].res, v[i].cout, v[i].ovf, v[i].zero}) begin
                failures++;
                $display("FAIL add[%0d] %h+%h+%b: got res=%h cout=%b ovf=%b zero=%b, want res=%h cout=%b ovf=%b zero=%b",
                         i, v[i].a, v[i].b, v[i].ci, res, cout, ovf, zero,
                         v[i].res, v[i].cout, v[i].ovf, v[i].zero);
            end else
                $display("add[%0d] %h+%h+%b -> res=%h cout=%b ovf=%b zero=%b",
                         i, v[i].a, v[i].b, v[i].ci, res, cout, ovf, zero);
        end
    endtask

    task automatic test_sub();
        vec_t v[$];
        v.push_back({3'd1, 32'h00000004, 32'h00000003, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0});
        v.push_back({3'd1, 32'h00000003, 32'h00000004, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0});
        v.push_back({3'd1, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0});
        // cin must be ignored by SUB
        v.push_back({3'd1, 32'h00000009, 32'h00000009, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1});
        v.push_back({3'd1, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0});
        foreach (v[i]) begin
            drive(v[i].cmd, v[i].a, v[i].b, v[i].ci);
            checks++;
            if ({res, cout, ovf, zero} !== {v[i].res, v[i].cout, v[i].ovf, v[i].zero}) begin
                failures++;
                $display("FAIL sub[%0d] %h-%h: got res=%h cout=%b ovf=%b zero=%b, want res=%h cout=%b ovf=%b zero=%b",
                         i, v[i].a, v[i].b, res, cout, ovf, zero,
                         v[i].res, v[i].cout, v[i].ovf, v[i].zero);
            end else
                $display("sub[%0d] %h-%h -> res=%h cout=%b ovf=%b zero=%b",
                         i, v[i].a, v[i].b, res, cout, ovf, zero);
        end
    endtask

    task automatic test_logic();
        vec_t v[$];
        v.push_back({3'd4, 32'h1F063821, 32'h3FFF0E11, 1'b1, 32'h1F060801, 1'b0, 1'b0, 1'b0});
        v.push_back({3'd7, 32'h1F063821, 32'h3FFF0E11, 1'b1, 32'h3FFF3E31, 1'b0, 1'b0, 1'b0});
        v.push_back({3'd6, 32'h1F063821, 32'h3FFF0E11, 1'b1, 32'hC000C1CE, 1'b0, 1'b0, 1'b0});
        v.push_back({3'd2, 32'h1F063821, 32'h3FFF0E11, 1'b1, 32'h20F93630, 1'b0, 1'b0, 1'b0});
        v.push_back({3'd2, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1});
        v.push_back({3'd6, 32'hFFFFFFFF, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1});
        foreach (v[i]) begin
            drive(v[i].cmd, v[i].a, v[i].b, v[i].ci);
            checks++;
            if ({res, cout, ovf, zero} !== {v[i].res, v[i].cout, v[i].ovf, v[i].zero}) begin
                failures++;
                $display("FAIL logic[%0d] cmd=%0d: got res=%h cout=%b ovf=%b zero=%b, want res=%h cout=%b ovf=%b zero=%b",
                         i, v[i].cmd, res, cout, ovf, zero,
                         v[i].res, v[i].cout, v[i].ovf, v[i].zero);
            end else
                $display("logic[%0d] cmd=%0d %h,%h -> res=%h zero=%b",
                         i, v[i].cmd, v[i].a, v[i].b, res, zero);
        end
    endtask

    task automatic test_slt();
        vec_t v[$];
        v.push_back({3'd3, 32'h00000001, 32'h04000001, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0});
        v.push_back({3'd3, 32'h20000001, 32'h00000001, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1});
        v.push_back({3'd3, 32'h80000000, 32'h7FFFFFFF, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0});
        v.push_back({3'd3, 32'h7FFFFFFF, 32'h80000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1});
        v.push_back({3'd3, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0});
        v.push_back({3'd3, 32'h00000005, 32'h00000005, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1});
        foreach (v[i]) begin
            drive(v[i].cmd, v[i].a, v[i].b, v[i].ci);
            checks++;
            if ({res, cout, ovf, zero} !== {v[i].res, v[i].cout, v[i].ovf, v[i].zero}) begin
                failures++;
                $display("FAIL slt[%0d] %h<%h: got res=%h cout=%b ovf=%b zero=%b, want res=%h cout=%b ovf=%b zero=%b",
                         i, v[i].a, v[i].b, res, cout, ovf, zero,
                         v[i].res, v[i].cout, v[i].ovf, v[i].zero);
            end else
                $display("slt[%0d] %h<%h -> res=%h zero=%b", i, v[i].a, v[i].b, res, zero);
        end
    endtask

    task automatic test_error();
        vec_t v[$];
        v.push_back({3'd5, 32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1});
        v.push_back({3'd5, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1});
        foreach (v[i]) begin
            drive(v[i].cmd, v[i].a, v[i].b, v[i].ci);
            checks++;
            if ({res, cout, ovf, zero} !== {v[i].res, v[i].cout, v[i].ovf, v[i].zero}) begin
                failures++;
                $display("FAIL error[%0d]: got res=%h cout=%b ovf=%b zero=%b, want res=00000000 cout=0 ovf=0 zero=1",
                         i, res, cout, ovf, zero);
            end else
                $display("error[%0d] -> res=%h zero=%b", i, res, zero);
        end
    endtask

    task automatic test_back_to_back();
        vec_t v[$];
        // Alternating ops whose results all differ, so a stale or skipped
        // result on any cycle shows up.
        v.push_back({3'd0, 32'h00000010, 32'h00000020, 1'b0, 32'h00000030, 1'b0, 1'b0, 1'b0});
        v.push_back({3'd1, 32'h00000010, 32'h00000020, 1'b0, 32'hFFFFFFF0, 1'b1, 1'b0, 1'b0});
        v.push_back({3'd7, 32'h0000F000, 32'h0000000F, 1'b0, 32'h0000F00F, 1'b0, 1'b0, 1'b0});
        v.push_back({3'd5, 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1});
        v.push_back({3'd0, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1});
        v.push_back({3'd4, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 32'h0F000F00, 1'b0, 1'b0, 1'b0});
        foreach (v[i]) begin
            drive(v[i].cmd, v[i].a, v[i].b, v[i].ci);
            checks++;
            if ({res, cout, ovf, zero} !== {v[i].res, v[i].cout, v[i].ovf, v[i].zero}) begin
                failures++;
                $display("FAIL b2b[%0d] cmd=%0d: got res=%h cout=%b ovf=%b zero=%b, want res=%h cout=%b ovf=%b zero=%b",
                         i, v[i].cmd, res, cout, ovf, zero,
                         v[i].res, v[i].cout, v[i].ovf, v[i].zero);
            end else
                $display("b2b[%0d] cmd=%0d -> res=%h cout=%b ovf=%b zero=%b",
                         i, v[i].cmd, res, cout, ovf, zero);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        opA      = 32'd0;
        opB      = 32'd0;
        cin      = 1'b0;
        cmd      = 3'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_slt();
        test_error();
        test_back_to_back();
        test_sync_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_alu.md
MIPS_ALU -- requirements
Module: mips_alu

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset, with ports named clk and reset_n.
REQ-002 Parameters SHALL be none; widths are fixed.
REQ-003 Port: clk  input  1  rising-edge clock; all state updates on this edge.
REQ-004 Port: reset_n  input  1  synchronous active-low reset.
REQ-005 Port: opA  input  32  operand A, two's complement.
REQ-006 Port: opB  input  32  operand B, two's complement.
REQ-007 Port: cin  input  1  carry-in, used by ADD only.
REQ-008 Port: cmd  input  3  operation select.
REQ-009 Port: res  output  32  registered result.
REQ-010 Port: zero  output  1  registered flag, 1 when res is all zeros.
REQ-011 Port: ovf  output  1  registered signed-overflow flag.
REQ-012 Port: cout  output  1  registered carry/borrow flag.

Function
REQ-013 cmd encoding SHALL be: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 ERROR, 6 NOR, 7 OR.
REQ-014 Timing: opA, opB, cin and cmd are sampled on a rising clk edge where reset_n=1; res and all flags SHALL reflect them after that edge (1-cycle latency) and hold until the next edge.
REQ-015 Throughput: one new operation SHALL be accepted every cycle, with no handshake and no stall.
REQ-016 ADD: res = (opA + opB + cin) mod 2^32.
  - cout = carry out of bit 31.
  - ovf = 1 when both operands have the same sign and the result sign differs.
REQ-017 SUB: res = (opA - opB) mod 2^32, computed as opA + ~opB + 1; cin is ignored.
  - cout = borrow, i.e. 1 iff opA < opB unsigned (the inverse of the raw adder carry).
  - ovf = 1 when the operand signs differ and the result sign differs from opA.
REQ-018 XOR, AND, OR, NOR: res = bitwise opA^opB, opA&opB, opA|opB, ~(opA|opB) respectively; cout=0, ovf=0.
REQ-019 SLT: res = 32'd1 if opA < opB as signed values, else 32'd0.
  - Compare via (opA - opB)[31] XOR subtract-overflow, so the result is correct at extreme values.
  - cout=0, ovf=0.
REQ-020 ERROR (cmd=5): res=0, cout=0, ovf=0, zero=1.
REQ-021 zero SHALL equal 1 iff the registered res is 32'd0, for every cmd.
REQ-022 cout and ovf SHALL be 0 for every cmd other than ADD and SUB.
REQ-023 No X SHALL propagate to outputs for any known input combination; wrap-around is modulo 2^32 with no saturation.

Reset
REQ-024 On a rising clk edge with reset_n=0, the outputs SHALL become res=0, cout=0, ovf=0, zero=1.
REQ-025 Reset SHALL take priority over any operation sampled on the same edge; the operation is discarded.
REQ-026 The first edge with reset_n=1 SHALL capture the operation present at that edge.
REQ-027 Reset SHALL have no asynchronous effect; outputs SHALL change only on clk edges.

Verification
REQ-028 ADD, cin=0: 0x00000001 + 0x00000001 -> res=0x00000002, cout=0, ovf=0, zero=0 one cycle later.
REQ-029 ADD carry and zero:
  - 0xFFFFFFFF + 0x00000001 -> res=0, cout=1, ovf=0, zero=1.
  - 0xFFFFFFFB + 0x80000000 -> res=0x7FFFFFFB, cout=1, ovf=1, zero=0.
REQ-030 Logic ops, opA=0x1F063821, opB=0x3FFF0E11 (cout=0, ovf=0, zero=0 for all):
  - AND -> 0x1F060801.
  - OR -> 0x3FFF3E31.
  - NOR -> 0xC000C1CE.
  - XOR -> 0x20F93630.
REQ-031 SUB and SLT:
  - SUB 4-3 -> res=1, cout=0, ovf=0, zero=0.
  - SLT 0x00000001 vs 0x04000001 -> res=1, zero=0.
  - SLT 0x20000001 vs 0x00000001 -> res=0, zero=1.
  - SLT 0x80000000 vs 0x7FFFFFFF -> res=1.
REQ-032 ERROR and reset:
  - cmd=5 with any operands -> res=0, cout=0, ovf=0, zero=1.
  - reset_n=0 on the same edge as ADD 0xFFFFFFFF + 0xFFFFFFFF -> reset values (res=0, zero=1, cout=0, ovf=0).
  - Back-to-back operations on consecutive cycles each appear exactly one cycle after being applied.
